periph_readout_mb: RTL and testbench
====================================

Name: periph_readout_mb

Overview:
- Parametrised successor of the peripheral readout for the pixel matrix periphery.
- Latches one row of hit bits from NBANK banks and scans each bank group-by-group.
- For every non-empty pixel group it pulses that group's read-tree clock and pushes a tagged word into a per-bank FIFO.
- Drains the FIFOs byte-serially under the Inquiry/Select protocol. DataOut/DataK feed the downstream 8b10b encoder.

Parameters:
- NBANK, 4, number of banks (1..4).
- NPIX, 48, hit bits per bank.
- GRP, 3, bits per pixel group. NPIX must be a multiple of GRP. NGRP = NPIX/GRP.
- ROW_W, 9, row address width.
- FIFO_DEPTH, 8, words per bank FIFO (power of 2, >=2).
- Derived: CIDX_W = clog2(NGRP). WORD_W = ROW_W + CIDX_W + GRP, which must be <=16. The word is zero-padded at the MSB to 16 bits.

Ports:
- CLK_80M  in  1  system clock, all logic on the rising edge.
- RST  in  1  asynchronous active-high reset.
- DataIn  in  NBANK*NPIX  hit bits; bank b occupies [b*NPIX +: NPIX].
- RowAddr  in  ROW_W  row tag, sampled together with RowLoad.
- RowLoad  in  1  one-cycle request to latch a new row.
- ReadTreeClk  out  NBANK*NGRP  one-cycle read-tree pulse per group; bank b occupies [b*NGRP +: NGRP].
- ValidOut  out  NBANK  per-bank FIFO non-empty.
- Busy  out  1  any bank still scanning.
- ReadEn  in  1  enables FIFO pops.
- Inquiry  in  2  00 sync, 01 data, 10 status, 11 idle.
- Select  in  clog2(NBANK) (min 1)  bank chosen for data.
- DataOut  out  8  output byte.
- DataK  out  1  DataOut is a K-symbol.

Behaviour:
- Reset values: ReadTreeClk=0, ValidOut=0, Busy=0, DataOut=8'hBC, DataK=1. All FIFOs empty, snapshots 0, byte phases 0, DropFlag 0.
- Reset mid-scan aborts the scan immediately; no pulses are issued afterwards.
- RowLoad accepted only when Busy=0:
  - At edge E, each bank snapshot <= its DataIn slice, row register <= RowAddr.
  - Busy=1 after E if any snapshot is non-zero.
  - RowLoad with Busy=1 is ignored and sets sticky DropFlag.
- Per-bank scanner, states IDLE/SCAN, independent per bank:
  - In SCAN, each edge picks the lowest g with snapshot group g non-zero.
  - If that bank's FIFO is not full: clear group g in the snapshot, push word {pad, row, g[CIDX_W-1:0], group bits}, and drive ReadTreeClk[g]=1 for exactly the following cycle.
  - If the FIFO is full: stall. No pulse, snapshot unchanged.
  - When the snapshot reaches 0: go to IDLE.
- Busy = OR of all banks in SCAN.
- Scan rate is at most one word per bank per cycle. A row with k hit groups finishes in k cycles when there is no stall.
- Full is evaluated on the pre-edge count. A push is blocked when full even if a pop occurs on the same edge.
- ValidOut[b] = count_b != 0 (registered count).
- Output stage is registered: Inquiry/Select sampled at edge n, result visible after edge n.
  - 00: DataOut=8'h3C, DataK=1. All byte phases reset to 0.
  - 01, bank s=Select:
    - If s>=NBANK, or ReadEn=0, or FIFO s is empty: DataOut=8'h1C, DataK=1, phase unchanged, no pop.
    - Otherwise phase_s=0 outputs head[15:8] and sets phase_s=1.
    - phase_s=1 outputs head[7:0], pops, and sets phase_s=0.
    - DataK=0 for both data bytes.
  - 10: DataOut={Busy, DropFlag, 2'b00, ValidOut zero-extended to 4}, DataK=0. DropFlag is cleared on the same edge.
    - If a RowLoad drop occurs on that same edge, DropFlag stays 1.
  - 11: DataOut=8'hBC, DataK=1.
- Byte phase is held per bank. Switching Select mid-word does not corrupt the other bank's half-read word.
- A pop and a scanner push on the same bank in the same cycle are both applied; count is unchanged.

Test Plan:
- Reset, then RowAddr=5, bank0 DataIn=48'h0000_0000_0140 (group 2 = 3'b101), RowLoad -> one cycle later ReadTreeClk[2]=1 for one cycle, ValidOut[0]=1. Inquiry=01, Select=0, ReadEn=1 for 2 cycles -> bytes 8'h02, 8'h95 with DataK=0, then ValidOut[0]=0.
- All 16 groups of bank1 hit, FIFO_DEPTH=8, no reads -> exactly 8 pulses on ReadTreeClk[NGRP+0..7], then a stall with Busy=1. Reading 1 word -> exactly one further pulse follows.
- RowLoad while Busy=1 -> snapshot unchanged. Inquiry=10 -> DataOut=8'hC?, bit6 set. A second status read shows bit6=0.
- Inquiry=01 with an empty FIFO or ReadEn=0 -> 8'h1C, DataK=1, no pop. Inquiry=00 -> 8'h3C, and after a half-read word the next data byte is again the high byte.
- Interleave Select 0/1 mid-word -> each bank's words are reconstructed intact.
- Assert RST mid-scan -> all outputs return to reset values within the same cycle (asynchronous). After release, no stale ReadTreeClk pulses.

Source files
------------

// File: rtl/periph_readout_mb.sv
// Pixel-periphery row readout: per-bank group scanners fill per-bank FIFOs,
// which are drained byte-serially under the Inquiry/Select protocol.
module periph_readout_mb #(
    parameter int unsigned NBANK      = 4,
    parameter int unsigned NPIX       = 48,
    parameter int unsigned GRP        = 3,
    parameter int unsigned ROW_W      = 9,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned NGRP      = NPIX / GRP,
    localparam int unsigned SEL_W     = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                  CLK_80M,
    input  logic                  RST,
    input  logic [NBANK*NPIX-1:0] DataIn,
    input  logic [ROW_W-1:0]      RowAddr,
    input  logic                  RowLoad,
    output logic [NBANK*NGRP-1:0] ReadTreeClk,
    output logic [NBANK-1:0]      ValidOut,
    output logic                  Busy,
    input  logic                  ReadEn,
    input  logic [1:0]            Inquiry,
    input  logic [SEL_W-1:0]      Select,
    output logic [7:0]            DataOut,
    output logic                  DataK
);
    localparam int unsigned CIDX_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {S_IDLE, S_SCAN} scan_state_t;

    scan_state_t             state_q   [NBANK];
    scan_state_t             state_d   [NBANK];
    logic [NPIX-1:0]         snap_q    [NBANK];
    logic [NPIX-1:0]         snap_d    [NBANK];
    logic [15:0]             push_word [NBANK];
    logic [15:0]             mem       [NBANK][FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q    [NBANK];
    logic [PTR_W-1:0]        rptr_q    [NBANK];
    logic [CNT_W-1:0]        cnt_q     [NBANK];
    logic [CNT_W-1:0]        cnt_d     [NBANK];
    logic [ROW_W-1:0]        row_q;
    logic [NBANK-1:0]        push;
    logic [NBANK-1:0]        pop;
    logic [NBANK-1:0]        phase_q;
    logic [NBANK-1:0]        phase_d;
    logic [NBANK*NGRP-1:0]   pulse_d;
    logic                    load;
    logic                    busy_d;
    logic                    found;
    int unsigned             gidx;
    logic                    drop_q;
    logic                    drop_d;
    logic                    sel_ok;
    logic [15:0]             head;
    logic [7:0]              dout_d;
    logic                    dk_d;

    // Scanners: each bank pushes its lowest non-empty group per cycle unless its FIFO is full
    always_comb begin
        load    = RowLoad && !Busy;
        pulse_d = '0;
        busy_d  = 1'b0;
        push    = '0;
        found   = 1'b0;
        gidx    = 0;
        for (int unsigned b = 0; b < NBANK; b++) begin
            snap_d[b]    = snap_q[b];
            state_d[b]   = state_q[b];
            push_word[b] = '0;
            found        = 1'b0;
            gidx         = 0;
            for (int unsigned g = 0; g < NGRP; g++) begin
                if (!found && (snap_q[b][g*GRP +: GRP] != '0)) begin
                    found = 1'b1;
                    gidx  = g;
                end
            end
            case (state_q[b])
                S_IDLE: begin
                    if (load) begin
                        snap_d[b] = DataIn[b*NPIX +: NPIX];
                        if (DataIn[b*NPIX +: NPIX] != '0) state_d[b] = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (found && (cnt_q[b] != CNT_W'(FIFO_DEPTH))) begin
                        snap_d[b][gidx*GRP +: GRP] = '0;
                        push[b]                    = 1'b1;
                        push_word[b]               = 16'({row_q, CIDX_W'(gidx),
                                                          snap_q[b][gidx*GRP +: GRP]});
                        pulse_d[b*NGRP + gidx]     = 1'b1;
                    end
                    if (snap_d[b] == '0) state_d[b] = S_IDLE;
                end
                default: state_d[b] = S_IDLE;
            endcase
            busy_d   = busy_d | (state_d[b] == S_SCAN);
            cnt_d[b] = cnt_q[b] + CNT_W'(push[b]) - CNT_W'(pop[b]);
        end
    end

    // Output stage: byte-serial drain with per-bank byte phase
    always_comb begin
        pop     = '0;
        phase_d = phase_q;
        drop_d  = drop_q;
        dout_d  = 8'hBC;
        dk_d    = 1'b1;
        sel_ok  = 32'(Select) < NBANK;
        head    = mem[Select][rptr_q[Select]];
        case (Inquiry)
            2'b00: begin
                dout_d  = 8'h3C;
                phase_d = '0;
            end
            2'b01: begin
                dout_d = 8'h1C;
                if (sel_ok && ReadEn && (cnt_q[Select] != '0)) begin
                    dk_d = 1'b0;
                    if (!phase_q[Select]) begin
                        dout_d          = head[15:8];
                        phase_d[Select] = 1'b1;
                    end else begin
                        dout_d          = head[7:0];
                        phase_d[Select] = 1'b0;
                        pop[Select]     = 1'b1;
                    end
                end
            end
            2'b10: begin
                dout_d = {Busy, drop_q, 2'b00, 4'(ValidOut)};
                dk_d   = 1'b0;
                drop_d = 1'b0;
            end
            default: ;
        endcase
        // a drop on the clearing edge wins so it is never lost
        if (RowLoad && Busy) drop_d = 1'b1;
    end

    always_ff @(posedge CLK_80M or posedge RST) begin
        if (RST) begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                state_q[b] <= S_IDLE;
                snap_q[b]  <= '0;
                wptr_q[b]  <= '0;
                rptr_q[b]  <= '0;
                cnt_q[b]   <= '0;
            end
            row_q       <= '0;
            phase_q     <= '0;
            drop_q      <= 1'b0;
            ReadTreeClk <= '0;
            ValidOut    <= '0;
            Busy        <= 1'b0;
            DataOut     <= 8'hBC;
            DataK       <= 1'b1;
        end else begin
            for (int unsigned b = 0; b < NBANK; b++) begin
                state_q[b]  <= state_d[b];
                snap_q[b]   <= snap_d[b];
                cnt_q[b]    <= cnt_d[b];
                ValidOut[b] <= (cnt_d[b] != '0);
                if (push[b]) wptr_q[b] <= wptr_q[b] + PTR_W'(1);
                if (pop[b])  rptr_q[b] <= rptr_q[b] + PTR_W'(1);
            end
            if (load) row_q <= RowAddr;
            phase_q     <= phase_d;
            drop_q      <= drop_d;
            ReadTreeClk <= pulse_d;
            Busy        <= busy_d;
            DataOut     <= dout_d;
            DataK       <= dk_d;
        end
    end

    // FIFO storage needs no reset; only entries below the count are ever read
    always_ff @(posedge CLK_80M) begin
        for (int unsigned b = 0; b < NBANK; b++) begin
            if (push[b]) mem[b][wptr_q[b]] <= push_word[b];
        end
    end

endmodule

// File: tb/tb_periph_readout_mb.sv
// Directed bench for periph_readout_mb: queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_periph_readout_mb;
    localparam int NBANK = 4;
    localparam int NPIX  = 48;
    localparam int GRP   = 3;
    localparam int NGRP  = 16;
    localparam int ROW_W = 9;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NBANK*NPIX-1:0] data_in;
    logic [ROW_W-1:0]      row_addr;
    logic                  row_load;
    logic [NBANK*NGRP-1:0] rtc;
    logic [NBANK-1:0]      valid;
    logic                  busy;
    logic                  read_en;
    logic [1:0]            inquiry;
    logic [1:0]            select;
    logic [7:0]            dout;
    logic                  dk;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    periph_readout_mb dut (
        .CLK_80M    (clk),
        .RST        (rst),
        .DataIn     (data_in),
        .RowAddr    (row_addr),
        .RowLoad    (row_load),
        .ReadTreeClk(rtc),
        .ValidOut   (valid),
        .Busy       (busy),
        .ReadEn     (read_en),
        .Inquiry    (inquiry),
        .Select     (select),
        .DataOut    (dout),
        .DataK      (dk)
    );

    always #5 clk = ~clk;

    // Reference model state: remaining hits per bank, word queues, byte phases
    logic [NPIX-1:0]       m_snap  [NBANK];
    logic [15:0]           m_fifo  [NBANK][$];
    bit                    m_phase [NBANK];
    bit                    m_drop;
    logic [ROW_W-1:0]      m_row;
    logic [NBANK*NGRP-1:0] e_rtc;
    logic [NBANK-1:0]      e_valid;
    logic                  e_busy;
    logic [7:0]            e_dout;
    logic                  e_dk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         busy_pre;
        logic [3:0] valid_pre;
        int         size_pre [NBANK];
        logic [15:0] word;
        int         g_hit;
        logic [2:0] bits;
        busy_pre  = 1'b0;
        valid_pre = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (m_snap[b] != 0) busy_pre = 1'b1;
            size_pre[b]  = m_fifo[b].size();
            valid_pre[b] = (size_pre[b] != 0);
        end
        e_dout = 8'hBC;
        e_dk   = 1'b1;
        case (inquiry)
            2'b00: begin
                e_dout = 8'h3C;
                for (int b = 0; b < NBANK; b++) m_phase[b] = 1'b0;
            end
            2'b01: begin
                e_dout = 8'h1C;
                if (int'(select) < NBANK && read_en && size_pre[select] != 0) begin
                    word = m_fifo[select][0];
                    e_dk = 1'b0;
                    if (!m_phase[select]) begin
                        e_dout = word[15:8];
                        m_phase[select] = 1'b1;
                    end else begin
                        e_dout = word[7:0];
                        m_phase[select] = 1'b0;
                        void'(m_fifo[select].pop_front());
                    end
                end
            end
            2'b10: begin
                e_dout = {busy_pre, m_drop, 2'b00, valid_pre};
                e_dk   = 1'b0;
                m_drop = 1'b0;
            end
            default: ;
        endcase
        if (row_load && busy_pre) m_drop = 1'b1;
        e_rtc = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (m_snap[b] != 0 && size_pre[b] < DEPTH) begin
                g_hit = 0;
                for (int g = NGRP - 1; g >= 0; g--)
                    if (((m_snap[b] >> (g * GRP)) & 48'h7) != 0) g_hit = g;
                bits = 3'(m_snap[b] >> (g_hit * GRP));
                m_fifo[b].push_back(16'(int'(m_row) * 128 + g_hit * 8 + int'(bits)));
                m_snap[b] = m_snap[b] & ~(48'h7 << (g_hit * GRP));
                e_rtc[b * NGRP + g_hit] = 1'b1;
            end
        end
        if (row_load && !busy_pre) begin
            m_row = row_addr;
            for (int b = 0; b < NBANK; b++) m_snap[b] = data_in[b*NPIX +: NPIX];
        end
        e_busy = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            e_valid[b] = (m_fifo[b].size() != 0);
            if (m_snap[b] != 0) e_busy = 1'b1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NBANK; b++) begin
                m_snap[b] = '0;
                m_fifo[b].delete();
                m_phase[b] = 1'b0;
            end
            m_drop  = 1'b0;
            m_row   = '0;
            e_rtc   = '0;
            e_valid = '0;
            e_busy  = 1'b0;
            e_dout  = 8'hBC;
            e_dk    = 1'b1;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("rtc", 64'(rtc), 64'(e_rtc));
        check("valid", 64'(valid), 64'(e_valid));
        check("busy", 64'(busy), 64'(e_busy));
        check("dout", 64'(dout), 64'(e_dout));
        check("dk", 64'(dk), 64'(e_dk));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            pulse_cnt += $countones(rtc);
        end
    endtask

    logic [7:0] exp5 [8];
    logic       expk5 [8];

    initial begin
        data_in  = '0;
        row_addr = '0;
        row_load = 1'b0;
        read_en  = 1'b0;
        inquiry  = 2'b11;
        select   = '0;
        exp5  = '{8'h91, 8'h91, 8'h81, 8'h9A, 8'h91, 8'h1C, 8'hAE, 8'h1C};
        expk5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_dout", 64'(dout), 64'h00BC);
        check("rst_dk", 64'(dk), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        rst = 1'b0;
        tick();

        // single group hit on bank0
        row_addr = 9'd5;
        data_in[47:0] = 48'h0000_0000_0140;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_rtc_none", 64'(rtc), 64'd0);
        tick();
        check("t1_rtc", 64'(rtc), 64'h4);
        check("t1_valid", 64'(valid), 64'h1);
        tick();
        check("t1_rtc_off", 64'(rtc), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);
        inquiry = 2'b01; select = 2'd0; read_en = 1'b1;
        tick();
        check("t1_hi", 64'({dk, dout}), 64'h002);
        tick();
        check("t1_lo", 64'({dk, dout}), 64'h095);
        check("t1_empty", 64'(valid), 64'd0);
        inquiry = 2'b11;

        // full bank1 row: stall at FIFO depth, one pulse per freed word
        data_in = '0;
        data_in[NPIX +: NPIX] = '1;
        row_addr = 9'h1A3;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        pulse_cnt = 0;
        run(12);
        check("t2_pulses", 64'(pulse_cnt), 64'd8);
        check("t2_stall_busy", 64'(busy), 64'd1);
        check("t2_valid", 64'(valid), 64'h2);
        inquiry = 2'b01; select = 2'd1;
        pulse_cnt = 0;
        run(1);
        check("t2_hi", 64'({dk, dout}), 64'h0D1);
        run(1);
        check("t2_lo", 64'({dk, dout}), 64'h087);
        inquiry = 2'b11;
        run(4);
        check("t2_one_more", 64'(pulse_cnt), 64'd1);

        // dropped RowLoad and status reads
        data_in = '1;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        inquiry = 2'b10;
        tick();
        check("t3_status_drop", 64'({dk, dout}), 64'h0C2);
        tick();
        check("t3_status_clr", 64'({dk, dout}), 64'h082);
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        check("t3_status_simul", 64'({dk, dout}), 64'h082);
        tick();
        check("t3_drop_kept", 64'({dk, dout}), 64'h0C2);
        tick();
        check("t3_status_clr2", 64'({dk, dout}), 64'h082);

        // idle data replies
        inquiry = 2'b01; select = 2'd1; read_en = 1'b0;
        tick();
        check("t4_readen0", 64'({dk, dout}), 64'h11C);
        check("t4_no_pop", 64'(valid), 64'h2);
        select = 2'd0; read_en = 1'b1;
        tick();
        check("t4_empty", 64'({dk, dout}), 64'h11C);
        select = 2'd3;
        tick();
        check("t4_empty3", 64'({dk, dout}), 64'h11C);
        select = 2'd1;
        run(40);
        check("t4_drained_busy", 64'(busy), 64'd0);
        check("t4_drained_valid", 64'(valid), 64'd0);
        inquiry = 2'b11;
        tick();

        // sync resets a half-read word
        data_in = '0;
        data_in[2*NPIX +: NPIX] = 48'h18;
        row_addr = 9'h0FF;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        tick();
        inquiry = 2'b01; select = 2'd2;
        tick();
        check("t5_hi", 64'({dk, dout}), 64'h07F);
        inquiry = 2'b00;
        tick();
        check("t5_sync", 64'({dk, dout}), 64'h13C);
        inquiry = 2'b01;
        tick();
        check("t5_hi_again", 64'({dk, dout}), 64'h07F);
        tick();
        check("t5_lo", 64'({dk, dout}), 64'h08B);
        inquiry = 2'b11;
        tick();

        // interleaved Select keeps per-bank phase
        data_in = '0;
        data_in[47:0] = 48'h0000_0003_0001;
        data_in[NPIX +: NPIX] = 48'h400;
        row_addr = 9'h123;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        run(3);
        inquiry = 2'b01;
        for (int i = 0; i < 8; i++) begin
            select = 2'(i % 2);
            tick();
            check("t6_interleave", 64'({dk, dout}), 64'({expk5[i], exp5[i]}));
        end
        inquiry = 2'b11;
        tick();

        // asynchronous reset mid-scan
        data_in = '0;
        data_in[NPIX +: NPIX] = '1;
        row_addr = '0;
        row_load = 1'b1;
        tick();
        row_load = 1'b0;
        run(2);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_rtc", 64'(rtc), 64'd0);
        check("t7_rst_busy", 64'(busy), 64'd0);
        check("t7_rst_valid", 64'(valid), 64'd0);
        check("t7_rst_out", 64'({dk, dout}), 64'h1BC);
        tick();
        rst = 1'b0;
        pulse_cnt = 0;
        run(5);
        check("t7_no_stale", 64'(pulse_cnt), 64'd0);
        check("t7_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
